argmax_classifier: RTL and testbench

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/nn_pkg.sv | 15 +
 rtl/argmax_classifier_if.sv | 37 +++
 rtl/argmax_cmp.sv | 17 +
 rtl/argmax_classifier.sv | 167 ++++++++++++++++
 tb/tb_argmax_classifier.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the argmax classifier.
package nn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

endpackage

// File: rtl/argmax_classifier_if.sv
// Score stream / result bundle for argmax_classifier.
// ARGMAX_MARGIN_EN adds the max_margin signal.
interface argmax_classifier_if #(
    parameter int SCORE_W = nn_pkg::SCORE_W,
    parameter int IDX_W   = nn_pkg::IDX_W,
    parameter int CNT_W   = nn_pkg::CNT_W
);
    logic                      start;
    logic                      score_valid;
    logic signed [SCORE_W-1:0] score_data;
    logic                      busy;
    logic [IDX_W-1:0]          result;
    logic                      batch_done;
    logic [CNT_W-1:0]          batch_count;
`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W-1:0]        max_margin;

    modport master (
        output start, score_valid, score_data,
        input  busy, result, batch_done, batch_count, max_margin
    );
    modport slave (
        input  start, score_valid, score_data,
        output busy, result, batch_done, batch_count, max_margin
    );
`else
    modport master (
        output start, score_valid, score_data,
        input  busy, result, batch_done, batch_count
    );
    modport slave (
        input  start, score_valid, score_data,
        output busy, result, batch_done, batch_count
    );
`endif

endinterface

// File: rtl/argmax_cmp.sv
// Strict signed greater-than with index select: ties keep the incumbent.
module argmax_cmp #(
    parameter int SCORE_W = 16,
    parameter int IDX_W   = 4
) (
    input  logic signed [SCORE_W-1:0] best_i,
    input  logic [IDX_W-1:0]          best_idx_i,
    input  logic signed [SCORE_W-1:0] cand_i,
    input  logic [IDX_W-1:0]          cand_idx_i,
    output logic                      gt_o,
    output logic [IDX_W-1:0]          win_idx_o
);

    assign gt_o      = cand_i > best_i;
    assign win_idx_o = gt_o ? cand_idx_i : best_idx_i;

endmodule

// File: rtl/argmax_classifier.sv
// Streaming argmax over NUM_CLASSES signed scores per sample.
// Define ARGMAX_MARGIN_EN to also report best minus second-best score.
module argmax_classifier #(
    parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int SCORE_W     = nn_pkg::SCORE_W,
    parameter int IDX_W       = nn_pkg::IDX_W,
    parameter int CNT_W       = nn_pkg::CNT_W
) (
    input logic               clk,
    input logic               rst,
    argmax_classifier_if.slave bus
);
    import nn_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          result_q, result_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic                      gt;
    logic [IDX_W-1:0]          win_idx;

    argmax_cmp #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_cmp_best (
        .best_i     (best_q),
        .best_idx_i (idx_q),
        .cand_i     (bus.score_data),
        .cand_idx_i (cnt_q),
        .gt_o       (gt),
        .win_idx_o  (win_idx)
    );

`ifdef ARGMAX_MARGIN_EN
    logic signed [SCORE_W-1:0] sec_q, sec_d;
    logic                      sec_vld_q, sec_vld_d;
    logic [SCORE_W-1:0]        margin_q, margin_d;
    logic signed [SCORE_W:0]   diff;
    logic                      gt2;
    logic [IDX_W-1:0]          win2_idx;
    logic                      unused_win2;

    argmax_cmp #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_cmp_sec (
        .best_i     (sec_q),
        .best_idx_i ('0),
        .cand_i     (bus.score_data),
        .cand_idx_i (cnt_q),
        .gt_o       (gt2),
        .win_idx_o  (win2_idx)
    );

    assign unused_win2 = ^win2_idx;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        best_d   = best_q;
        idx_d    = idx_q;
        result_d = result_q;
        count_d  = count_q;
`ifdef ARGMAX_MARGIN_EN
        sec_d     = sec_q;
        sec_vld_d = sec_vld_q;
        margin_d  = margin_q;
        diff      = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (bus.score_valid) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == '0) begin
                        best_d = bus.score_data;
                        idx_d  = '0;
                    end else begin
                        best_d = gt ? bus.score_data : best_q;
                        idx_d  = win_idx;
                    end
`ifdef ARGMAX_MARGIN_EN
                    // Displaced best becomes runner-up; else challenge runner-up.
                    if (cnt_q == '0) begin
                        sec_vld_d = 1'b0;
                    end else if (gt) begin
                        sec_d     = best_q;
                        sec_vld_d = 1'b1;
                    end else if (!sec_vld_q || gt2) begin
                        sec_d     = bus.score_data;
                        sec_vld_d = 1'b1;
                    end
`endif
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        result_d = idx_d;
                        count_d  = count_q + CNT_W'(1);
`ifdef ARGMAX_MARGIN_EN
                        diff = {best_d[SCORE_W-1], best_d}
                             - {sec_d[SCORE_W-1], sec_d};
                        if (!sec_vld_d)
                            margin_d = '0;
                        else if (diff[SCORE_W])
                            margin_d = '1;
                        else
                            margin_d = diff[SCORE_W-1:0];
`endif
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            best_q   <= '0;
            idx_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            best_q   <= best_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q     <= '0;
            sec_vld_q <= 1'b0;
            margin_q  <= '0;
        end else begin
            sec_q     <= sec_d;
            sec_vld_q <= sec_vld_d;
            margin_q  <= margin_d;
        end
    end

    assign bus.max_margin = margin_q;
`endif

    assign bus.busy        = (state_q == ACCUM);
    assign bus.batch_done  = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.batch_count = count_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: driver pushes expectations,
// negedge monitor pops and compares on every batch_done.
module tb_argmax_classifier;

    typedef logic signed [15:0] vec_t [10];

    typedef struct {
        logic [3:0]  res;
        logic [9:0]  cnt;
        logic [15:0] mar;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [9:0] exp_count = '0;
    exp_t q[$];

    argmax_classifier_if #(.SCORE_W(16), .IDX_W(4), .CNT_W(10)) ifc ();

    argmax_classifier dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ifc.batch_done === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got batch_done=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("result", ifc.result, e.res);
                chk("batch_count", ifc.batch_count, e.cnt);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", ifc.busy, 0);
`ifdef ARGMAX_MARGIN_EN
                chk("max_margin", ifc.max_margin, e.mar);
`endif
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ifc.start       = 1'b0;
            ifc.score_valid = 1'b0;
            ifc.score_data  = '0;
        end
    endtask

    task automatic run_sample(input vec_t v, input bit gap_en,
                              input logic [3:0] er, input logic [15:0] em,
                              input bit sv_with_start, input bit mid_start);
        exp_t e;
        int g;
        @(negedge clk);
        ifc.start       = 1'b1;
        ifc.score_valid = sv_with_start;
        ifc.score_data  = 16'sd100;
        for (int k = 0; k < 10; k++) begin
            g = gap_en ? (k % 4) : 0;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                chk("busy_gap", ifc.busy, 1);
                ifc.start       = mid_start && (k == 5);
                ifc.score_valid = 1'b0;
                ifc.score_data  = 16'sh7fff;
            end
            @(negedge clk);
            chk("busy_score", ifc.busy, 1);
            ifc.start       = mid_start && (k == 6);
            ifc.score_valid = 1'b1;
            ifc.score_data  = v[k];
            if (k == 9) begin
                exp_count = exp_count + 10'd1;
                e.res = er;
                e.cnt = exp_count;
                e.mar = em;
                e.cyc = cyc + 1;
                q.push_back(e);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t va, vext, vext0, vneg, vinc;
        va   = '{16'sd3, -16'sd2, 16'sd9, 16'sd1, 16'sd0,
                 16'sd4, 16'sd9, -16'sd7, 16'sd2, 16'sd5};
        vneg = '{-16'sd5, -16'sd1, -16'sd3, -16'sd1, -16'sd8,
                 -16'sd2, -16'sd9, -16'sd4, -16'sd6, -16'sd7};
        for (int i = 0; i < 10; i++) begin
            vext[i]  = (i == 9) ? 16'sh7fff : 16'sh8000;
            vext0[i] = (i == 0) ? 16'sh7fff : 16'sh8000;
            vinc[i]  = 16'(i + 1);
        end

        ifc.start       = 1'b0;
        ifc.score_valid = 1'b0;
        ifc.score_data  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", ifc.result, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.batch_done, 0);
        chk("rst_count", ifc.batch_count, 0);
        rst = 1'b0;
        idle(2);

        run_sample(va, 1'b0, 4'd2, 16'd0, 1'b0, 1'b0);
        idle(3);
        chk("count_after_first", ifc.batch_count, 1);
        chk("idle_busy", ifc.busy, 0);

        run_sample(va, 1'b1, 4'd2, 16'd0, 1'b0, 1'b0);
        idle(2);
        run_sample(vext, 1'b0, 4'd9, 16'hffff, 1'b0, 1'b0);
        idle(2);
        run_sample(vext0, 1'b1, 4'd0, 16'hffff, 1'b0, 1'b0);
        idle(2);
        run_sample(vneg, 1'b0, 4'd1, 16'd0, 1'b0, 1'b0);
        idle(2);

        run_sample(va, 1'b1, 4'd2, 16'd0, 1'b1, 1'b1);
        run_sample(vinc, 1'b0, 4'd9, 16'd1, 1'b0, 1'b0);
        idle(3);
        chk("result_hold", ifc.result, 9);

        @(negedge clk);
        ifc.start = 1'b1;
        ifc.score_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ifc.start       = 1'b0;
            ifc.score_valid = 1'b1;
            ifc.score_data  = vinc[k];
        end
        @(negedge clk);
        rst             = 1'b1;
        ifc.start       = 1'b1;
        ifc.score_valid = 1'b1;
        ifc.score_data  = 16'sd50;
        exp_count       = '0;
        @(negedge clk);
        rst             = 1'b0;
        ifc.start       = 1'b0;
        ifc.score_valid = 1'b0;
        chk("midrst_result", ifc.result, 0);
        chk("midrst_busy", ifc.busy, 0);
        chk("midrst_done", ifc.batch_done, 0);
        chk("midrst_count", ifc.batch_count, 0);
        idle(12);

        run_sample(vneg, 1'b1, 4'd1, 16'd0, 1'b0, 1'b0);
        idle(3);
        chk("count_after_rst", ifc.batch_count, 1);

        @(negedge clk);
        rst = 1'b1;
        exp_count = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 1024; s++)
            run_sample(va, 1'b0, 4'd2, 16'd0, 1'b0, 1'b0);
        idle(1);
        for (int t = 0; t < 20 && q.size() != 0; t++)
            idle(1);
        chk("queue_drained", q.size(), 0);
        chk("count_wrapped", ifc.batch_count, 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
